onchip_ram_arbiter: RTL and testbench
=====================================

// Module: onchip_ram_arbiter
// PURPOSE
//  Shares the single-port 32-bit on-chip RAM (32000 words, 1-cycle read latency) between two
//  Avalon-MM requesters (CPU data master, DMA). Arbitration is round-robin with one grant per cycle
//  and pipelined reads. Out-of-range accesses are trapped, and a sticky error flag is raised.
// PARAMETERS
//  ADDR_W    15     word-address width of requesters and RAM
//  DATA_W    32     data width; byteenable width = DATA_W/8
//  NUMWORDS  32000  implemented RAM depth; addresses >= NUMWORDS are out of range
// PORTS
//  clk              in   1         system clock
//  reset            in   1         synchronous, active-high reset
//  mN_address       in   ADDR_W    requester N word address (N = 0,1)
//  mN_byteenable    in   DATA_W/8  requester N byte lanes
//  mN_read          in   1         requester N read request
//  mN_write         in   1         requester N write request
//  mN_writedata     in   DATA_W    requester N write data
//  mN_waitrequest   out  1         request N not accepted this cycle
//  mN_readdata      out  DATA_W    read data for requester N
//  mN_readdatavalid out  1         mN_readdata valid this cycle
//  mem_address      out  ADDR_W    RAM address
//  mem_byteenable   out  DATA_W/8  RAM byte enables
//  mem_chipselect   out  1         RAM select
//  mem_write        out  1         RAM write enable (qualified by chipselect)
//  mem_writedata    out  DATA_W    RAM write data
//  mem_clken        out  1         RAM clock enable; tied 1
//  mem_readdata     in   DATA_W    RAM data; valid 1 cycle after a read is issued
//  oor_error        out  1         sticky out-of-range flag
//  oor_clear        in   1         clears oor_error
// BEHAVIOUR
//  - reqN = mN_read | mN_write. If read and write are asserted together, the access is treated as a write.
//  - Grant is combinational from reqN and a registered priority pointer prio
//    (0 = m0 first). One requester alone is granted. If both request, prio wins.
//  - mN_waitrequest = reqN & ~grantN. A granted request is accepted in that cycle.
//  - On an accepted access, prio <= index of the non-granted requester.
//    With no accepted access, prio holds.
//  - RAM muxing (combinational): mem_* is driven from the granted requester.
//    mem_chipselect = grant & in_range & ~reset.
//  - in_range = (address < NUMWORDS).
//  - Accepted read: registers rd_pend = 1 and rd_owner = N.
//    In the next cycle, mN_readdatavalid = 1 for rd_owner only.
//    mN_readdata = mem_readdata if the address was in range, else 0.
//    Fixed latency of 1 cycle. Back-to-back reads are allowed, one per cycle with no bubble.
//  - mN_readdata of the non-owner is 0.
//  - Accepted write: completes in the grant cycle. No response is returned.
//  - Out-of-range access (read or write): accepted normally, no RAM access, write dropped.
//    The read returns 0 with readdatavalid. oor_error <= 1 on the next clock.
//    oor_clear has priority over a same-cycle set; a same-cycle set is lost.
//  - Reset values (registers): prio = 0, rd_pend = 0, rd_owner = 0, rd_oor = 0, oor_error = 0.
//    Output values while reset is asserted: both readdatavalid = 0, both waitrequest = reqN, mem_chipselect = 0.
//  - Reset mid-read: a read accepted in the cycle before reset asserts produces no readdatavalid.
//    No response is produced after reset releases.
//  - There is no FSM beyond the prio and rd_pend registers, and no backpressure from the RAM side.
// TESTING
//  1. m0 write 0xDEADBEEF @0x0010 with be=4'hF, then m0 read @0x0010.
//     -> waitrequest 0 both cycles; readdatavalid 1 cycle after the read; readdata 0xDEADBEEF.
//  2. m0 and m1 hold read requests continuously for 6 cycles starting after reset.
//     -> grant order m0,m1,m0,m1,m0,m1; each requester waitrequest 1 on alternate cycles; 3 valids each.
//  3. m1 write @0x7D00 (32000).
//     -> accepted, mem_chipselect 0, oor_error 1 next cycle.
//     Then m1 read @0x7FFF -> readdatavalid with data 0.
//     Then oor_clear -> oor_error 0.
//  4. Write 0x11223344 @5, then write 0xAABBCCDD @5 with be=4'b0101, then read @5.
//     -> readdata 0x11BB33DD.
//  5. m0 read accepted, then reset pulsed in the following cycle.
//     -> m0_readdatavalid stays 0; after reset, prio = 0 (m0 wins a simultaneous request).
//  6. m1 alone issues 4 back-to-back reads @0..3, preloaded with 0xA0..0xA3.
//     -> waitrequest 0 throughout; valids on 4 consecutive cycles with data in order.

Source files
------------

// File: rtl/onchip_ram_arbiter.sv
// Two-requester arbiter in front of a single-port on-chip RAM.
// Round-robin grant, one access per cycle, 1-cycle pipelined reads,
// out-of-range accesses absorbed with a sticky error flag.
//
// Handshake: a requester asserts read and/or write (write wins when both are
// set) with address/byteenable/writedata stable; the access is accepted in
// any cycle where waitrequest is low. An accepted read returns exactly one
// readdatavalid pulse on the following cycle; an accepted write has no response.
module onchip_ram_arbiter #(
  parameter int ADDR_W   = 15,
  parameter int DATA_W   = 32,
  parameter int NUMWORDS = 32000
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic [ADDR_W-1:0]     m0_address,
  input  logic [DATA_W/8-1:0]   m0_byteenable,
  input  logic                  m0_read,
  input  logic                  m0_write,
  input  logic [DATA_W-1:0]     m0_writedata,
  output logic                  m0_waitrequest,
  output logic [DATA_W-1:0]     m0_readdata,
  output logic                  m0_readdatavalid,

  input  logic [ADDR_W-1:0]     m1_address,
  input  logic [DATA_W/8-1:0]   m1_byteenable,
  input  logic                  m1_read,
  input  logic                  m1_write,
  input  logic [DATA_W-1:0]     m1_writedata,
  output logic                  m1_waitrequest,
  output logic [DATA_W-1:0]     m1_readdata,
  output logic                  m1_readdatavalid,

  output logic [ADDR_W-1:0]     mem_address,
  output logic [DATA_W/8-1:0]   mem_byteenable,
  output logic                  mem_chipselect,
  output logic                  mem_write,
  output logic [DATA_W-1:0]     mem_writedata,
  output logic                  mem_clken,
  input  logic [DATA_W-1:0]     mem_readdata,

  output logic                  oor_error,
  input  logic                  oor_clear
);

  localparam int BE_W = DATA_W / 8;
  // Depth limit widened by one bit so NUMWORDS == 2**ADDR_W stays representable.
  localparam logic [ADDR_W:0] DEPTH = NUMWORDS[ADDR_W:0];

  logic              req0;
  logic              req1;
  logic              grant0;
  logic              grant1;
  logic              accept;

  // prio: 0 means m0 wins a tie, 1 means m1 wins a tie.
  logic              prio;
  logic              rd_pend;
  logic              rd_owner;
  logic              rd_oor;

  logic [ADDR_W-1:0] g_address;
  logic [BE_W-1:0]   g_byteenable;
  logic [DATA_W-1:0] g_writedata;
  logic              g_write;
  logic              g_read;
  logic              in_range;
  logic [DATA_W-1:0] rd_data;

  // Requests and round-robin grant; no grants are issued while in reset.
  always_comb begin
    req0   = m0_read | m0_write;
    req1   = m1_read | m1_write;
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!reset) begin
      grant0 = req0 & (~req1 | ~prio);
      grant1 = req1 & (~req0 |  prio);
    end
    accept         = grant0 | grant1;
    m0_waitrequest = req0 & ~grant0;
    m1_waitrequest = req1 & ~grant1;
  end

  // Select the granted requester's command; a simultaneous read+write is a write.
  always_comb begin
    g_address    = m0_address;
    g_byteenable = m0_byteenable;
    g_writedata  = m0_writedata;
    g_write      = grant0 & m0_write;
    g_read       = grant0 & m0_read & ~m0_write;
    if (grant1) begin
      g_address    = m1_address;
      g_byteenable = m1_byteenable;
      g_writedata  = m1_writedata;
      g_write      = m1_write;
      g_read       = m1_read & ~m1_write;
    end
    in_range = ({1'b0, g_address} < DEPTH);
  end

  // RAM port: only in-range granted accesses reach the memory.
  always_comb begin
    mem_address    = g_address;
    mem_byteenable = g_byteenable;
    mem_writedata  = g_writedata;
    mem_chipselect = accept & in_range & ~reset;
    mem_write      = mem_chipselect & g_write;
    mem_clken      = 1'b1;
  end

  // Priority pointer, read-pending tracking and sticky out-of-range flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      prio      <= 1'b0;
      rd_pend   <= 1'b0;
      rd_owner  <= 1'b0;
      rd_oor    <= 1'b0;
      oor_error <= 1'b0;
    end else begin
      if (accept) begin
        prio <= grant0;
      end
      rd_pend <= g_read;
      if (g_read) begin
        rd_owner <= grant1;
        rd_oor   <= ~in_range;
      end
      if (oor_clear) begin
        oor_error <= 1'b0;
      end else if (accept && !in_range) begin
        oor_error <= 1'b1;
      end
    end
  end

  // Read response routing; out-of-range reads return zero, non-owner sees zero.
  always_comb begin
    rd_data          = rd_oor ? '0 : mem_readdata;
    m0_readdatavalid = rd_pend & ~rd_owner & ~reset;
    m1_readdatavalid = rd_pend &  rd_owner & ~reset;
    m0_readdata      = m0_readdatavalid ? rd_data : '0;
    m1_readdata      = m1_readdatavalid ? rd_data : '0;
  end

endmodule

// File: tb/tb_onchip_ram_arbiter.sv
// Bench for onchip_ram_arbiter: directed scenarios followed by random traffic,
// checked cycle by cycle against a transaction-level model (tie-break pointer,
// shadow memory, per-requester expected read-data queues).
module tb_onchip_ram_arbiter;

  localparam int ADDR_W   = 15;
  localparam int DATA_W   = 32;
  localparam int NUMWORDS = 32000;

  logic              clk;
  logic              reset;
  logic [ADDR_W-1:0] m0_address;
  logic [3:0]        m0_byteenable;
  logic              m0_read;
  logic              m0_write;
  logic [31:0]       m0_writedata;
  logic              m0_waitrequest;
  logic [31:0]       m0_readdata;
  logic              m0_readdatavalid;
  logic [ADDR_W-1:0] m1_address;
  logic [3:0]        m1_byteenable;
  logic              m1_read;
  logic              m1_write;
  logic [31:0]       m1_writedata;
  logic              m1_waitrequest;
  logic [31:0]       m1_readdata;
  logic              m1_readdatavalid;
  logic [ADDR_W-1:0] mem_address;
  logic [3:0]        mem_byteenable;
  logic              mem_chipselect;
  logic              mem_write;
  logic [31:0]       mem_writedata;
  logic              mem_clken;
  logic [31:0]       mem_readdata;
  logic              oor_error;
  logic              oor_clear;

  onchip_ram_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUMWORDS(NUMWORDS)
  ) dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_clken(mem_clken), .mem_readdata(mem_readdata),
    .oor_error(oor_error), .oor_clear(oor_clear)
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port RAM with byte enables and 1-cycle read latency.
  logic [31:0] ram [0:32767];
  always @(posedge clk) begin
    if (mem_chipselect && mem_clken) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
        end
      end else begin
        mem_readdata <= ram[mem_address];
      end
    end
  end

  // Reference model state.
  logic [31:0] shadow [0:32767];
  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];
  int          prio_m;
  int          pend_owner;
  logic        oor_m;

  int          checks;
  int          failures;
  int          cnt_v0;
  int          cnt_v1;
  logic [31:0] last_rd0;
  logic [31:0] last_rd1;

  task automatic check1(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, got, exp);
    end
  endtask

  task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // One clock cycle: check outputs at the falling edge, advance the model,
  // then return just after the rising edge so new inputs can be applied.
  task automatic tick();
    logic        r0, r1, wr, inr, ev0, ev1;
    int          win, ai;
    logic [14:0] a;
    logic [3:0]  be;
    logic [31:0] wd, e0, e1;
    @(negedge clk);
    r0  = m0_read | m0_write;
    r1  = m1_read | m1_write;
    win = -1;
    if (!reset) begin
      if (r0 && r1)  win = prio_m;
      else if (r0)   win = 0;
      else if (r1)   win = 1;
    end
    a  = (win == 1) ? m1_address    : m0_address;
    be = (win == 1) ? m1_byteenable : m0_byteenable;
    wd = (win == 1) ? m1_writedata  : m0_writedata;
    wr = (win == 1) ? m1_write      : m0_write;
    ai = int'(a);
    inr = (ai < NUMWORDS);

    check1("m0_waitrequest", m0_waitrequest, r0 && (win != 0));
    check1("m1_waitrequest", m1_waitrequest, r1 && (win != 1));
    check1("mem_chipselect", mem_chipselect, (win >= 0) && inr);
    check1("mem_write", mem_write, (win >= 0) && inr && wr);
    if ((win >= 0) && inr) check32("mem_address", {17'b0, mem_address}, {17'b0, a});
    check1("mem_clken", mem_clken, 1'b1);

    ev0 = !reset && (pend_owner == 0);
    ev1 = !reset && (pend_owner == 1);
    e0 = 32'h0;
    e1 = 32'h0;
    if (pend_owner == 0 && exp_q0.size() > 0) begin
      if (ev0) e0 = exp_q0[0];
      void'(exp_q0.pop_front());
    end
    if (pend_owner == 1 && exp_q1.size() > 0) begin
      if (ev1) e1 = exp_q1[0];
      void'(exp_q1.pop_front());
    end
    check1("m0_readdatavalid", m0_readdatavalid, ev0);
    check1("m1_readdatavalid", m1_readdatavalid, ev1);
    check32("m0_readdata", m0_readdata, e0);
    check32("m1_readdata", m1_readdata, e1);
    check1("oor_error", oor_error, oor_m);
    if (m0_readdatavalid) begin cnt_v0++; last_rd0 = m0_readdata; end
    if (m1_readdatavalid) begin cnt_v1++; last_rd1 = m1_readdata; end

    if (reset) begin
      prio_m     = 0;
      pend_owner = -1;
      oor_m      = 1'b0;
    end else begin
      pend_owner = -1;
      if (win >= 0) begin
        if (wr) begin
          if (inr) begin
            for (int b = 0; b < 4; b++) begin
              if (be[b]) shadow[ai][8*b +: 8] = wd[8*b +: 8];
            end
          end
        end else begin
          pend_owner = win;
          if (win == 0) exp_q0.push_back(inr ? shadow[ai] : 32'h0);
          else          exp_q1.push_back(inr ? shadow[ai] : 32'h0);
        end
        prio_m = 1 - win;
      end
      if (oor_clear)                oor_m = 1'b0;
      else if ((win >= 0) && !inr)  oor_m = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  // Driver tasks.
  task automatic set_m0(input logic rd, input logic wr, input logic [14:0] a,
                        input logic [3:0] be, input logic [31:0] wd);
    m0_read = rd; m0_write = wr; m0_address = a; m0_byteenable = be; m0_writedata = wd;
  endtask

  task automatic set_m1(input logic rd, input logic wr, input logic [14:0] a,
                        input logic [3:0] be, input logic [31:0] wd);
    m1_read = rd; m1_write = wr; m1_address = a; m1_byteenable = be; m1_writedata = wd;
  endtask

  task automatic idle();
    set_m0(1'b0, 1'b0, 15'h0, 4'h0, 32'h0);
    set_m1(1'b0, 1'b0, 15'h0, 4'h0, 32'h0);
  endtask

  function automatic logic [14:0] rand_addr();
    if ($urandom_range(0, 7) == 0) return 15'($urandom_range(32000, 32767));
    return 15'($urandom_range(0, 31));
  endfunction

  initial begin
    checks = 0; failures = 0; cnt_v0 = 0; cnt_v1 = 0;
    last_rd0 = '0; last_rd1 = '0;
    prio_m = 0; pend_owner = -1; oor_m = 1'b0;
    mem_readdata = '0;
    for (int i = 0; i < 32768; i++) begin ram[i] = '0; shadow[i] = '0; end
    reset = 1'b1; oor_clear = 1'b0;
    idle();
    #1;

    // Reset state, including waitrequest = request while held in reset.
    tick();
    set_m0(1'b1, 1'b0, 15'h10, 4'hF, 32'h0);
    set_m1(1'b0, 1'b1, 15'h20, 4'hF, 32'h5);
    tick();
    idle();
    tick();
    reset = 1'b0;

    // Write then read back on m0.
    set_m0(1'b0, 1'b1, 15'h10, 4'hF, 32'hDEADBEEF); tick();
    set_m0(1'b1, 1'b0, 15'h10, 4'hF, 32'h0);        tick();
    idle();                                           tick();
    check32("t1_readback", last_rd0, 32'hDEADBEEF);

    // Continuous contention straight after reset alternates m0, m1.
    reset = 1'b1; tick(); reset = 1'b0;
    cnt_v0 = 0; cnt_v1 = 0;
    set_m0(1'b1, 1'b0, 15'h10, 4'hF, 32'h0);
    set_m1(1'b1, 1'b0, 15'h11, 4'hF, 32'h0);
    for (int i = 0; i < 6; i++) tick();
    idle(); tick();
    check32("t2_valids_m0", 32'(cnt_v0), 32'd3);
    check32("t2_valids_m1", 32'(cnt_v1), 32'd3);

    // Out-of-range write and read, then clear.
    set_m1(1'b0, 1'b1, 15'h7D00, 4'hF, 32'h12345678); tick();
    idle();
    check1("t3_oor_set", oor_error, 1'b1);
    set_m1(1'b1, 1'b0, 15'h7FFF, 4'hF, 32'h0); tick();
    idle(); last_rd1 = 32'hFFFFFFFF; tick();
    check32("t3_oor_read", last_rd1, 32'h0);
    oor_clear = 1'b1; tick(); oor_clear = 1'b0;
    check1("t3_oor_clear", oor_error, 1'b0);

    // Byte-enable merge.
    set_m0(1'b0, 1'b1, 15'd5, 4'hF,    32'h11223344); tick();
    set_m0(1'b0, 1'b1, 15'd5, 4'b0101, 32'hAABBCCDD); tick();
    set_m0(1'b1, 1'b0, 15'd5, 4'hF,    32'h0);        tick();
    idle(); tick();
    check32("t4_merge", last_rd0, 32'h11BB33DD);

    // Reset right after an accepted read kills the response and resets prio.
    cnt_v0 = 0;
    set_m0(1'b1, 1'b0, 15'h10, 4'hF, 32'h0); tick();
    idle(); reset = 1'b1; tick(); reset = 1'b0;
    check32("t5_no_valid", 32'(cnt_v0), 32'd0);
    set_m0(1'b1, 1'b0, 15'h10, 4'hF, 32'h0);
    set_m1(1'b1, 1'b0, 15'h11, 4'hF, 32'h0);
    @(negedge clk);
    check1("t5_m0_wins", m0_waitrequest, 1'b0);
    check1("t5_m1_waits", m1_waitrequest, 1'b1);
    @(posedge clk); #1;
    prio_m = 1; pend_owner = 0; exp_q0.push_back(shadow[16]);
    idle(); tick();

    // Back-to-back reads on m1 from preloaded words.
    for (int i = 0; i < 4; i++) begin
      ram[i] = 32'hA0 + 32'(i);
      shadow[i] = 32'hA0 + 32'(i);
    end
    cnt_v1 = 0;
    for (int i = 0; i < 4; i++) begin
      set_m1(1'b1, 1'b0, 15'(i), 4'hF, 32'h0);
      tick();
    end
    idle(); tick();
    check32("t6_valids", 32'(cnt_v1), 32'd4);
    check32("t6_last", last_rd1, 32'hA3);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      reset     = ($urandom_range(0, 39) == 0);
      oor_clear = ($urandom_range(0, 9) == 0);
      set_m0(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0), rand_addr(),
             4'($urandom_range(0, 15)), $urandom);
      set_m1(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0), rand_addr(),
             4'($urandom_range(0, 15)), $urandom);
      tick();
    end
    reset = 1'b0; oor_clear = 1'b0;
    idle(); tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
